// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the port arbiter and the unified memory.
// The arbiter takes the slave view; the CPU side and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch and load/store,
// with a single transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic { IDLE, WAIT } state_t;
  typedef enum logic [1:0] { OWN_NONE, OWN_IF, OWN_D } owner_t;
  typedef enum logic { REQ_IF, REQ_D } req_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  req_t              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;

  logic              if_win;
  logic              d_win;

  logic              if_gnt, d_gnt, if_rvalid, d_rvalid;
  logic [DATA_W-1:0] if_rdata, d_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;

  // On contention the requester that did not win last time takes the port.
  assign if_win = bus.if_req && (!bus.d_req || (last_q == REQ_D));
  assign d_win  = bus.d_req && !if_win;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    store_d   = store_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    // Outputs stay at zero for the whole time reset is held, even the combinational ones.
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (if_win) begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = bus.if_addr;
            owner_d  = OWN_IF;
            last_d   = REQ_IF;
            store_d  = 1'b0;
            cnt_d    = CNT_LOAD;
            state_d  = WAIT;
          end else if (d_win) begin
            d_gnt     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
            mem_wstrb = bus.d_we ? bus.d_wstrb : '0;
            owner_d   = OWN_D;
            last_d    = REQ_D;
            store_d   = bus.d_we;
            cnt_d     = CNT_LOAD;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = bus.mem_rdata;
            end else if (owner_q == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = store_q ? '0 : bus.mem_rdata;
            end
            owner_d = OWN_NONE;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wstrb = mem_wstrb;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      last_q  <= REQ_D;
      cnt_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LATENCY=2: reset, round-robin, single fetch,
// store ack, busy stall and reset during an outstanding load.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"},    32'(bus.if_gnt),    32'h0);
    check({tag, ".d_gnt"},     32'(bus.d_gnt),     32'h0);
    check({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'h0);
    check({tag, ".d_rvalid"},  32'(bus.d_rvalid),  32'h0);
    check({tag, ".if_rdata"},  bus.if_rdata,       32'h0);
    check({tag, ".d_rdata"},   bus.d_rdata,        32'h0);
    check({tag, ".mem_req"},   32'(bus.mem_req),   32'h0);
    check({tag, ".mem_we"},    32'(bus.mem_we),    32'h0);
    check({tag, ".mem_addr"},  bus.mem_addr,       32'h0);
    check({tag, ".mem_wdata"}, bus.mem_wdata,      32'h0);
    check({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
  endtask

  initial begin
    logic [31:0] exp_rd;
    total = 0;
    bad   = 0;

    rst           = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0010;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0000_0300;
    bus.d_wdata   = 32'h1111_2222;
    bus.d_wstrb   = 4'hF;
    bus.mem_rdata = 32'h5555_AAAA;
    #2 rst = 1'b0;

    // T1: outputs held at zero while reset is asserted, even with both requests high.
    #1 check_all_zero("t1_rst_a");
    tick();
    tick();
    check_all_zero("t1_rst_b");
    rst = 1'b0;

    // T1/T3: release with both requesting; IF first, then D, IF, D at cycles 0,3,6,9.
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.mem_rdata = 32'hA000_0000 | c;
      if (c == 10) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      #1;
      check($sformatf("t3_if_gnt_c%0d", c),    32'(bus.if_gnt),    32'((c % 6) == 0));
      check($sformatf("t3_d_gnt_c%0d", c),     32'(bus.d_gnt),     32'((c % 6) == 3));
      check($sformatf("t3_mem_req_c%0d", c),   32'(bus.mem_req),   32'((c % 3) == 0));
      check($sformatf("t3_if_rvalid_c%0d", c), 32'(bus.if_rvalid), 32'((c % 6) == 2));
      check($sformatf("t3_d_rvalid_c%0d", c),  32'(bus.d_rvalid),  32'((c % 6) == 5));
      exp_rd = ((c % 6) == 2) ? (32'hA000_0000 | c) : 32'h0;
      check($sformatf("t3_if_rdata_c%0d", c), bus.if_rdata, exp_rd);
      exp_rd = ((c % 6) == 5) ? (32'hA000_0000 | c) : 32'h0;
      check($sformatf("t3_d_rdata_c%0d", c), bus.d_rdata, exp_rd);
      if ((c % 6) == 0) check($sformatf("t3_mem_addr_c%0d", c), bus.mem_addr, 32'h0000_0010);
      if ((c % 6) == 3) check($sformatf("t3_mem_addr_c%0d", c), bus.mem_addr, 32'h0000_0300);
      tick();
    end

    // T2: single fetch from 0x10, data back two cycles later.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    #1;
    check("t2_if_gnt",    32'(bus.if_gnt),    32'h1);
    check("t2_d_gnt",     32'(bus.d_gnt),     32'h0);
    check("t2_mem_req",   32'(bus.mem_req),   32'h1);
    check("t2_mem_addr",  bus.mem_addr,       32'h0000_0010);
    check("t2_mem_we",    32'(bus.mem_we),    32'h0);
    check("t2_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("t2_mem_wdata", bus.mem_wdata,      32'h0);
    tick();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'hFFFF_FFF0;
    bus.mem_rdata = 32'h0050_0093;
    #1;
    check("t2_c1_mem_req",   32'(bus.mem_req),   32'h0);
    check("t2_c1_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    tick();
    check("t2_c2_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("t2_c2_if_rdata",  bus.if_rdata,       32'h0050_0093);
    check("t2_c2_d_rvalid",  32'(bus.d_rvalid),  32'h0);
    check("t2_c2_d_rdata",   bus.d_rdata,        32'h0);
    tick();
    check("t2_c3_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    check("t2_c3_mem_req",   32'(bus.mem_req),   32'h0);

    // T4: store of 0xDEADBEEF to 0x100, acked with zero data.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_wstrb = 4'hF;
    #1;
    check("t4_d_gnt",     32'(bus.d_gnt),     32'h1);
    check("t4_if_gnt",    32'(bus.if_gnt),    32'h0);
    check("t4_mem_req",   32'(bus.mem_req),   32'h1);
    check("t4_mem_we",    32'(bus.mem_we),    32'h1);
    check("t4_mem_addr",  bus.mem_addr,       32'h0000_0100);
    check("t4_mem_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
    check("t4_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
    tick();
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    check("t4_c1_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    tick();
    check("t4_c2_d_rvalid",  32'(bus.d_rvalid),  32'h1);
    check("t4_c2_d_rdata",   bus.d_rdata,        32'h0);
    check("t4_c2_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    tick();

    // T5: load request arrives while a fetch is in flight and stalls until IDLE.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    #1;
    check("t5_if_gnt", 32'(bus.if_gnt), 32'h1);
    tick();
    bus.if_req    = 1'b0;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0000_0140;
    bus.d_wstrb   = 4'hA;
    bus.mem_rdata = 32'h0BAD_F00D;
    #1;
    check("t5_c1_d_gnt",   32'(bus.d_gnt),   32'h0);
    check("t5_c1_mem_req", 32'(bus.mem_req), 32'h0);
    tick();
    check("t5_c2_d_gnt",     32'(bus.d_gnt),     32'h0);
    check("t5_c2_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("t5_c2_if_rdata",  bus.if_rdata,       32'h0BAD_F00D);
    check("t5_c2_d_rvalid",  32'(bus.d_rvalid),  32'h0);
    tick();
    check("t5_c3_d_gnt",     32'(bus.d_gnt),     32'h1);
    check("t5_c3_mem_addr",  bus.mem_addr,       32'h0000_0140);
    check("t5_c3_mem_we",    32'(bus.mem_we),    32'h0);
    check("t5_c3_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);

    // T6: reset in cycle 1 of that load; its rvalid must never appear.
    tick();
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'hCAFE_0001;
    rst           = 1'b0;
    #1 check_all_zero("t6_rst_now");
    tick();
    check_all_zero("t6_rst_hold");
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("t6_idle_mem_req_c%0d", c),  32'(bus.mem_req),  32'h0);
      check($sformatf("t6_idle_d_rvalid_c%0d", c), 32'(bus.d_rvalid), 32'h0);
      check($sformatf("t6_idle_d_rdata_c%0d", c),  bus.d_rdata,       32'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
